// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel/line counters advanced by a pixel-enable tick,
// with registered sync, blanking and line/frame start pulses.
module vga_sync_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic       CLK_in,
   input  logic       reset,
   input  logic       pix_tick,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       line_start,
   output logic       frame_start
);

   localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  HLast    = 10'(HTotal - 1);
   localparam logic [9:0]  VLast    = 10'(VTotal - 1);
   // 11-bit bounds so an active width of exactly 1024 still compares correctly
   localparam logic [10:0] HAct     = 11'(H_ACTIVE);
   localparam logic [10:0] HSyncBeg = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HSyncEnd = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VAct     = 11'(V_ACTIVE);
   localparam logic [10:0] VSyncBeg = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VSyncEnd = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0]  x_d, y_d;
   logic [10:0] x_ext, y_ext;
   logic        hsync_d, vsync_d, video_on_d, line_start_d, frame_start_d;

   always_comb begin
      x_d = pixel_x;
      y_d = pixel_y;
      if (pix_tick) begin
         if (pixel_x == HLast) begin
            x_d = '0;
            y_d = (pixel_y == VLast) ? '0 : pixel_y + 10'd1;
         end else begin
            x_d = pixel_x + 10'd1;
         end
      end
   end

   // Levels come from the next position so they line up with the counters they accompany
   assign x_ext = {1'b0, x_d};
   assign y_ext = {1'b0, y_d};

   always_comb begin
      video_on_d    = (x_ext < HAct) && (y_ext < VAct);
      hsync_d       = ((x_ext >= HSyncBeg) && (x_ext < HSyncEnd)) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = ((y_ext >= VSyncBeg) && (y_ext < VSyncEnd)) ? SYNC_POL : ~SYNC_POL;
      line_start_d  = pix_tick && (x_d == '0);
      frame_start_d = line_start_d && (y_d == '0);
   end

   // Reset parks on the last position so the first tick opens a complete frame
   always_ff @(posedge CLK_in or posedge reset) begin
      if (reset) begin
         pixel_x     <= HLast;
         pixel_y     <= VLast;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         video_on    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pixel_x     <= x_d;
         pixel_y     <= y_d;
         hsync       <= hsync_d;
         vsync       <= vsync_d;
         video_on    <= video_on_d;
         line_start  <= line_start_d;
         frame_start <= frame_start_d;
      end
   end

endmodule
